btn_sw_debounce: RTL and testbench



---
 rtl/btn_sw_debounce.sv | 72 +++++++
 tb/tb_btn_sw_debounce.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/btn_sw_debounce.sv
// btn_sw_debounce: 2-FF synchronisers + tick-qualified debounce for one button and NUM_SW switches.
// Define BTN_IRQ_LATCH_EN for a sticky irq_o cleared by irq_ack_i; otherwise irq_o is a one-cycle press pulse.
module btn_sw_debounce #(
  parameter int NUM_SW       = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              btn_raw_i,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic              btn_o,
  output logic [NUM_SW-1:0] sw_o,
  output logic              irq_o
`ifdef BTN_IRQ_LATCH_EN
  ,
  input  logic              irq_ack_i
`endif
);
  localparam int N  = NUM_SW + 1;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;
  logic [N-1:0]  s1, s, d;
  logic [PW-1:0] pc;
  logic          tick, btn_q, press;
  assign tick = (TICK_DIV == 1) || (pc == PW'(TICK_DIV - 1));
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      s1 <= '0;
      s  <= '0;
      pc <= '0;
    end else begin
      s1 <= {btn_raw_i, sw_raw_i};
      s  <= s1;
      pc <= tick ? '0 : pc + 1'b1;
    end
  // button is the top channel; any cycle with s==d restarts qualification
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CW-1:0] c;
    logic          d_r;
    assign d[i] = d_r;
    always_ff @(posedge clk_i or negedge arst_n_i)
      if (!arst_n_i) begin
        c   <= '0;
        d_r <= 1'b0;
      end else if (s[i] == d_r) begin
        c <= '0;
      end else if (tick) begin
        if (c == CW'(STABLE_TICKS - 1)) begin
          d_r <= s[i];
          c   <= '0;
        end else begin
          c <= c + 1'b1;
        end
      end
  end
  assign btn_o = d[NUM_SW];
  assign sw_o  = d[NUM_SW-1:0];
  assign press = d[NUM_SW] & ~btn_q;
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      btn_q <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      btn_q <= d[NUM_SW];
`ifdef BTN_IRQ_LATCH_EN
      irq_o <= press | (irq_o & ~irq_ack_i);
`else
      irq_o <= press;
`endif
    end
endmodule

// File: tb/tb_btn_sw_debounce.sv
// tb_btn_sw_debounce: directed + random stimulus against a tick-counting reference model.
module tb_btn_sw_debounce;
  localparam int NSW = 16, TD = 4, ST = 3, N = NSW + 1;
  logic clk = 0, arst_n = 0, btn_raw = 0;
  logic [NSW-1:0] sw_raw = '0;
  logic btn, irq;
  logic [NSW-1:0] sw;
`ifdef BTN_IRQ_LATCH_EN
  logic irq_ack = 0;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  btn_sw_debounce #(.NUM_SW(NSW), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .btn_raw_i(btn_raw), .sw_raw_i(sw_raw),
    .btn_o(btn), .sw_o(sw), .irq_o(irq)
`ifdef BTN_IRQ_LATCH_EN
    , .irq_ack_i(irq_ack)
`endif
  );
  // model: a mismatch streak starting at cycle m is accepted at the tick cycle that is its ST-th tick
  logic [N-1:0] s1m, sm, dm;
  bit act[N];
  int start[N];
  int n;
  logic dprev, irqm;
  task automatic mreset();
    s1m = '0; sm = '0; dm = '0; n = 0; dprev = 0; irqm = 0;
    foreach (act[i]) act[i] = 0;
  endtask
  task automatic model_edge();
    logic pr;
    pr = dm[NSW] & ~dprev;
`ifdef BTN_IRQ_LATCH_EN
    irqm = pr | (irqm & ~irq_ack);
`else
    irqm = pr;
`endif
    dprev = dm[NSW];
    for (int i = 0; i < N; i++) begin
      if (sm[i] === dm[i]) act[i] = 0;
      else begin
        if (!act[i]) begin act[i] = 1; start[i] = n; end
        if (n % TD == TD - 1 && (n + 1) / TD - start[i] / TD == ST) begin
          dm[i] = sm[i];
          act[i] = 0;
        end
      end
    end
    sm = s1m;
    s1m = {btn_raw, sw_raw};
    n++;
  endtask
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic compare();
    check("btn", 32'(btn), 32'(dm[NSW]));
    check("sw", 32'(sw), 32'(dm[NSW-1:0]));
    check("irq", 32'(irq), 32'(irqm));
  endtask
  task automatic step();
    @(posedge clk);
    if (arst_n) model_edge();
    #1;
    compare();
  endtask
  initial begin
    int lat;
    bit bad;
    mreset();
    btn_raw = 1; sw_raw = '1;
    #2;
    compare();
    repeat (5) step();
    btn_raw = 0; sw_raw = '0; arst_n = 1;
    repeat (20) step();
    btn_raw = 1; lat = 0;
    while (btn !== 1'b1 && lat < 40) begin step(); lat++; end
    check("press_latency", 32'(lat >= 11 && lat <= 14), 1);
    check("irq_not_yet", 32'(irq), 0);
    step();
    check("irq_pulse", 32'(irq), 1);
    step();
`ifdef BTN_IRQ_LATCH_EN
    check("irq_sticky", 32'(irq), 1);
    repeat (20) step();
    check("irq_held", 32'(irq), 1);
    irq_ack = 1; step(); irq_ack = 0;
    check("irq_acked", 32'(irq), 0);
    irq_ack = 1; step(); irq_ack = 0;
    check("ack_idle", 32'(irq), 0);
`else
    check("irq_one_cycle", 32'(irq), 0);
`endif
    btn_raw = 0; lat = 0;
    while (btn !== 1'b0 && lat < 14) begin step(); lat++; end
    check("release_done", 32'(btn), 0);
    repeat (3) step();
    check("release_no_irq", 32'(irq), 0);
`ifdef BTN_IRQ_LATCH_EN
    btn_raw = 1; lat = 0;
    while (btn !== 1'b1 && lat < 40) begin step(); lat++; end
    irq_ack = 1; step(); irq_ack = 0;
    check("set_wins", 32'(irq), 1);
    irq_ack = 1; step(); irq_ack = 0;
    btn_raw = 0;
    repeat (20) step();
    check("second_release", 32'(btn), 0);
`endif
    bad = 0;
    btn_raw = 1; repeat (6) begin step(); bad |= btn | irq; end
    btn_raw = 0; repeat (2) begin step(); bad |= btn | irq; end
    btn_raw = 1; repeat (6) begin step(); bad |= btn | irq; end
    btn_raw = 0; repeat (20) begin step(); bad |= btn | irq; end
    check("bounce_rejected", 32'(bad), 0);
    sw_raw = 16'hA5C3; lat = 0;
    while (sw !== 16'hA5C3 && lat < 14) begin step(); lat++; end
    check("sw_accept", 32'(sw), 32'h0000A5C3);
    bad = 0;
    sw_raw[0] = 0; repeat (3) begin step(); bad |= (sw !== 16'hA5C3); end
    sw_raw[0] = 1; repeat (20) begin step(); bad |= (sw !== 16'hA5C3) | btn | irq; end
    check("sw_glitch", 32'(bad), 0);
    #3 arst_n = 0;
    #1;
    mreset();
    check("async_btn", 32'(btn), 0);
    check("async_sw", 32'(sw), 0);
    check("async_irq", 32'(irq), 0);
    @(posedge clk); #1;
    compare();
    arst_n = 1;
    repeat (30) step();
    check("reaccept_sw", 32'(sw), 32'h0000A5C3);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) sw_raw = 16'($urandom);
      if ($urandom_range(11) == 0) btn_raw = ~btn_raw;
`ifdef BTN_IRQ_LATCH_EN
      irq_ack = ($urandom_range(9) == 0);
`endif
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
